// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_t         : FSM state encoding (IDLE, SHIFT, DONE)
//   SA_DEFAULT_WIDTH: default operand/result width in bits
package serial_adder_pkg;

  localparam int SA_DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fulladd.sv
// One-bit full adder used as the per-bit arithmetic stage of serial_adder.
// Ports:
//   a, b, cin : operand bits and carry-in
//   s, cout   : sum bit and carry-out
module fulladd (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule : fulladd

// File: rtl/serial_adder.sv
// Bit-serial adder: computes s = (a + b + cin) mod 2^N and cout = bit N of
// the full sum, one bit per clock, LSB first.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-high reset
//   start : begin an addition (only honoured in IDLE)
//   a, b  : N-bit operands, captured on an accepted start
//   cin   : carry-in, captured on an accepted start
//   busy  : high while bits are being shifted (SHIFT state)
//   done  : one-cycle pulse when s/cout hold a fresh result
//   s     : registered N-bit sum
//   cout  : registered carry-out
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int N = SA_DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] s,
  output logic         cout
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t          state;
  state_t          next_state;
  logic [N-1:0]    op_a;
  logic [N-1:0]    op_b;
  logic [N-1:0]    result;
  logic            carry;
  logic [CW-1:0]   count;
  logic            sum_bit;
  logic            carry_out;
  logic            last_bit;

  fulladd u_fulladd (
    .a    (op_a[0]),
    .b    (op_b[0]),
    .cin  (carry),
    .s    (sum_bit),
    .cout (carry_out)
  );

  assign last_bit = (count == CW'(N - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; busy/done depend on the state register only, so no
  // input reaches an output combinationally.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) begin
          next_state = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath. The result register fills from the MSB end, so after N shifts
  // bit 0 of the sum has reached bit 0. The outputs are loaded from the
  // shifted value on the final SHIFT edge so the last sum bit is included
  // without waiting an extra cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      carry  <= 1'b0;
      count  <= '0;
      s      <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            count <= '0;
          end
        end
        SHIFT: begin
          result <= {sum_bit, result[N-1:1]};
          op_a   <= {1'b0, op_a[N-1:1]};
          op_b   <= {1'b0, op_b[N-1:1]};
          carry  <= carry_out;
          if (last_bit) begin
            s    <= {sum_bit, result[N-1:1]};
            cout <= carry_out;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule : serial_adder
